// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM encoding, default depth, requester ids.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT = 32;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/ram_rr_grant.sv
// Two-way round-robin grant: one-hot grant from valids, favouring the port not granted last.
module ram_rr_grant
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the 32x64 data RAM: IDLE -> ACCESS -> RESP, one response pulse per access.
// Optional RAM_ARBITER_STATS_EN adds saturating grant/error counters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_out
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_grants0,
  output logic [31:0]       stat_grants1,
  output logic [31:0]       stat_errors
`endif
);

  state_t              state, state_nxt;
  logic                last_grant;
  logic [1:0]          grant;
  logic                handshake;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                cap_port, cap_write, cap_err;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   rdata0, rdata1;
  logic [DATA_W-1:0]   load_val;

  ram_rr_grant u_grant (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_nxt    = state;
    handshake    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        handshake  = |grant;
        if (handshake) state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_read_en  = !cap_err && !cap_write;
        ram_write_en = !cap_err && cap_write;
        state_nxt    = RESP;
      end
      RESP: begin
        rsp0_valid = (cap_port == PORT_CPU);
        rsp1_valid = (cap_port == PORT_LOADER);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_write = grant[1] ? req1_write : req0_write;
    sel_addr  = grant[1] ? req1_addr  : req0_addr;
    sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    load_val  = (!cap_err && !cap_write) ? ram_out : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_LOADER;
      cap_port   <= PORT_CPU;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        cap_port   <= grant[1];
        last_grant <= grant[1];
        cap_write  <= sel_write;
        cap_addr   <= sel_addr;
        cap_wdata  <= sel_wdata;
        // Full-width compare so high address bits can never alias into the RAM.
        cap_err    <= (sel_addr >= ADDR_W'(DEPTH));
      end
      if (state == ACCESS) begin
        if (cap_port == PORT_CPU) rdata0 <= load_val;
        else                      rdata1 <= load_val;
      end
    end
  end

  assign ram_address = cap_addr;
  assign ram_data_in = cap_wdata;
  assign rsp0_rdata  = rdata0;
  assign rsp1_rdata  = rdata1;
  assign rsp0_err    = rsp0_valid && cap_err;
  assign rsp1_err    = rsp1_valid && cap_err;

`ifdef RAM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants0 <= '0;
      stat_grants1 <= '0;
      stat_errors  <= '0;
    end else begin
      if (handshake && grant[0] && (stat_grants0 != '1)) stat_grants0 <= stat_grants0 + 32'd1;
      if (handshake && grant[1] && (stat_grants1 != '1)) stat_grants1 <= stat_grants1 + 32'd1;
      if ((state == ACCESS) && cap_err && (stat_errors != '1)) stat_errors <= stat_errors + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 32x64 RAM (word[i] = i*100).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write;
  logic [63:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [63:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [63:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [63:0] rsp1_rdata;
  logic [63:0] ram_address, ram_data_in, ram_out;
  logic        ram_read_en, ram_write_en;
`ifdef RAM_ARBITER_STATS_EN
  logic [31:0] stat_grants0, stat_grants1, stat_errors;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_address(ram_address), .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_data_in(ram_data_in), .ram_out(ram_out)
`ifdef RAM_ARBITER_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_errors(stat_errors)
`endif
  );

  logic [63:0] mem [32];
  logic        init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'(i * 100);
    end else if (ram_write_en) begin
      mem[ram_address[4:0]] <= ram_data_in;
    end
  end
  assign ram_out = mem[ram_address[4:0]];

  int rd_cnt = 0, wr_cnt = 0, rsp0_cnt = 0, both_rdy_cnt = 0;
  int cyc = 0, hs_n = 0;
  int hs_port [64];
  int hs_cyc  [64];

  always @(negedge clk) begin
    if (ram_read_en)              rd_cnt       <= rd_cnt + 1;
    if (ram_write_en)             wr_cnt       <= wr_cnt + 1;
    if (rsp0_valid)               rsp0_cnt     <= rsp0_cnt + 1;
    if (req0_ready && req1_ready) both_rdy_cnt <= both_rdy_cnt + 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && hs_n < 64) begin
      if (req0_valid && req0_ready) begin
        hs_port[hs_n] <= 0; hs_cyc[hs_n] <= cyc; hs_n <= hs_n + 1;
      end else if (req1_valid && req1_ready) begin
        hs_port[hs_n] <= 1; hs_cyc[hs_n] <= cyc; hs_n <= hs_n + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input bit w, input logic [63:0] a, input logic [63:0] d);
    if (!p) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Issue one request, then check enables in ACCESS (N+1) and the response in RESP (N+2).
  task automatic access(input string tag, input bit p, input bit w, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp_rd, input bit exp_err);
    bit got_rdy;
    int en0;
    got_rdy = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    for (int n = 0; n < 10; n++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin
        got_rdy = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val({tag, " ready"}, 64'(got_rdy), 64'd1);
    if (!got_rdy) begin
      drive(p, 1'b0, w, a, d);
      return;
    end
    en0 = rd_cnt + wr_cnt;
    @(posedge clk);
    #1 drive(p, 1'b0, w, a, d);
    @(negedge clk);
    check_val({tag, " rd_en"}, 64'(ram_read_en), 64'(!w && !exp_err));
    check_val({tag, " wr_en"}, 64'(ram_write_en), 64'(w && !exp_err));
    check_val({tag, " rsp early"}, 64'(p ? rsp1_valid : rsp0_valid), 64'd0);
    @(negedge clk);
    check_val({tag, " rsp_valid"}, 64'(p ? rsp1_valid : rsp0_valid), 64'd1);
    check_val({tag, " other rsp"}, 64'(p ? rsp0_valid : rsp1_valid), 64'd0);
    check_val({tag, " rdata"}, p ? rsp1_rdata : rsp0_rdata, exp_rd);
    check_val({tag, " err"}, 64'(p ? rsp1_err : rsp0_err), 64'(exp_err));
    check_val({tag, " en pulses"}, 64'(rd_cnt + wr_cnt - en0), exp_err ? 64'd0 : 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int base;
    int rsp_before;

    reset = 1'b1;
    init_mem = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    check_val("reset ram_address", ram_address, 64'd0);
    check_val("reset ram_data_in", ram_data_in, 64'd0);
    check_val("reset enables", {62'd0, ram_read_en, ram_write_en}, 64'd0);
    check_val("reset rsp", {60'd0, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}, 64'd0);
    check_val("reset rdata0", rsp0_rdata, 64'd0);
    check_val("reset rdata1", rsp1_rdata, 64'd0);
    reset = 1'b0;

    // Basic load with latency, then hold behaviour in the following idle cycle.
    access("ld5", 1'b0, 1'b0, 64'd5, 64'd0, 64'd500, 1'b0);
    check_val("ld5 addr in RESP", ram_address, 64'd5);
    @(negedge clk);
    check_val("ld5 pulse width", 64'(rsp0_valid), 64'd0);
    check_val("ld5 rdata hold", rsp0_rdata, 64'd500);
    check_val("ld5 addr hold", ram_address, 64'd5);

    // Out-of-range loads: full-width compare, no RAM activity.
    access("ld32", 1'b0, 1'b0, 64'd32, 64'd0, 64'd0, 1'b1);
    access("ldmax", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1);
    access("st40", 1'b1, 1'b1, 64'd40, 64'h55, 64'd0, 1'b1);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== 64'(i * 100)) bad++;
    check_val("mem intact", 64'(bad), 64'd0);

    // Store then load back on the loader port.
    access("st7", 1'b1, 1'b1, 64'd7, 64'hDEAD, 64'd0, 1'b0);
    access("ld7", 1'b1, 1'b0, 64'd7, 64'd0, 64'hDEAD, 1'b0);

    // Contention from reset: both ports load continuously.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'd1, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'd2, 64'd0);
    @(negedge clk);
    base = hs_n;
    rsp_before = both_rdy_cnt;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'd1, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd2, 64'd0);
    repeat (4) @(negedge clk);
    check_val("rr count", 64'(hs_n - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("rr grant%0d", k), 64'(hs_port[base + k]), 64'(k % 2));
      if (k > 0) check_val($sformatf("rr gap%0d", k), 64'(hs_cyc[base + k] - hs_cyc[base + k - 1]), 64'd3);
    end
    check_val("rr both ready", 64'(both_rdy_cnt - rsp_before), 64'd0);
    check_val("rr rdata0", rsp0_rdata, 64'd100);
    check_val("rr rdata1", rsp1_rdata, 64'd200);

    // Reset while in RESP: response suppressed, outputs cleared, store already done.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 64'd3, 64'h1234_5678);
    #1 check_val("rstresp ready", 64'(req0_ready), 64'd1);
    rsp_before = rsp0_cnt;
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b1, 64'd3, 64'h1234_5678);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_val("rstresp rsp0", 64'(rsp0_valid), 64'd0);
    check_val("rstresp addr", ram_address, 64'd0);
    check_val("rstresp data", ram_data_in, 64'd0);
    check_val("rstresp en", {62'd0, ram_read_en, ram_write_en}, 64'd0);
    check_val("rstresp rdata", rsp0_rdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rstresp no pulse", 64'(rsp0_cnt - rsp_before), 64'd0);

    // Post-reset traffic: 3 port-0 (one out of range), 2 port-1.
    access("ld3", 1'b0, 1'b0, 64'd3, 64'd0, 64'h1234_5678, 1'b0);
    access("ld40", 1'b0, 1'b0, 64'd40, 64'd0, 64'd0, 1'b1);
    access("ld4", 1'b0, 1'b0, 64'd4, 64'd0, 64'd400, 1'b0);
    access("ld1p1", 1'b1, 1'b0, 64'd1, 64'd0, 64'd100, 1'b0);
    access("ld31p1", 1'b1, 1'b0, 64'd31, 64'd0, 64'd3100, 1'b0);
`ifdef RAM_ARBITER_STATS_EN
    check_val("stat_grants0", 64'(stat_grants0), 64'd3);
    check_val("stat_grants1", 64'(stat_grants1), 64'd2);
    check_val("stat_errors", 64'(stat_errors), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
